rlbp_seq: RTL
=============

# rlbp_seq

Parametrised readout sequencer for the MixPix pixel array, the multi-channel successor to the single-pixel RLBP control macro. It drives the pixel switch and sample-hold phases (rst_o, Sh_rst, Sw1, Sh, Sw2, Sh_cmp, counter_rst) from programmable phase timers. It runs a shared single-slope counter that digitises NCH comparator inputs in parallel, then serialises the results on data_o. It sits behind the Caravel Wishbone slave port in the user project wrapper and raises irq[0] at end of frame.

## Interface
- NCH, 4: comparator channels, 1..8
- CW, 8: conversion counter and result width, 4..16
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  synchronous active-high reset
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone strobes
- wbs_adr_i  in  32  byte address; only [5:2] decoded
- wbs_dat_i  in  32  write data
- wbs_sel_i  in  4  byte selects; ignored, full-word writes only
- wbs_dat_o  out  32  read data
- wbs_ack_o  out  1  ack
- comp_i  in  NCH  asynchronous comparator outputs, one per channel
- rst_o, Sh_rst, Sw1, Sh, Sw2, Sh_cmp, counter_rst  out  1 each  pixel phase controls
- data_o  out  1  serial result bit
- clk_o  out  1  high in every cycle data_o carries a valid bit
- start_o  out  1  high with the first serial bit
- done_o  out  1  one-cycle end-of-frame pulse
- irq  out  3  irq[0] = DONE sticky; irq[2:1] = 0

## Operation
- Registers, word index wbs_adr_i[5:2]:
  - 0 CTRL: bit0 START (W1, self-clearing), bit1 CONT, bit2 ABORT (W1, self-clearing).
  - 1 TIMING: [7:0] T_RST, [15:8] T_INT, [23:16] T_SH.
  - 2 STATUS: bit0 BUSY (RO), bit1 DONE (sticky; any write to 2 clears it), [15:8] FRAMES (RO, wraps at 255).
  - 8+k RESULT k for k < NCH, RO, zero-extended.
  - Other addresses read 0; writes to them are dropped.
- FSM states: IDLE, RST, INT, SAMP, CONV, SHIFT, DONE.
- Each timed phase lasts max(T,1) cycles.
  - RST: rst_o=Sh_rst=counter_rst=1.
  - INT: Sw1=1, counter_rst=1.
  - SAMP: Sh=1, counter_rst=1.
  - CONV: Sw2=Sh_cmp=1. Counter runs 0..2^CW-1, one step per cycle, exactly 2^CW cycles.
  - Phase outputs are 0 in all other states.
- comp_i passes through a 2-flop synchroniser per channel. Channel k captures the counter value in the first CONV cycle its synchronised bit is high. Later edges are ignored. If the bit is never high, the channel captures 2^CW-1.
- At the CONV→SHIFT transition all RESULT registers update together. Reads during a frame return the previous frame's results.
- SHIFT lasts NCH*CW cycles. Order: channel 0 first, MSB first. clk_o=1 throughout; start_o=1 on the first bit only.
- DONE lasts 1 cycle: done_o=1, DONE sticky set, FRAMES+1. Next state is RST if CONT=1, else IDLE.
- START is accepted only in IDLE; in any other state it is ignored.
- ABORT forces IDLE from any state on the next cycle. RESULT, DONE and FRAMES are left unchanged. If START and ABORT are written together, ABORT wins.
- BUSY = state != IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, registers 0, RESULT 0, synchronisers 0.
- wb_rst_i asserted mid-frame: everything returns to reset values at the next edge.
- Ack: wbs_ack_o pulses 1 cycle after any cycle with cyc&stb&!ack. Exactly one cycle per access; no wait states. Read data is valid with ack.
- START write acked at edge E: RST is first active in the cycle after E.
- Frame length: max(T_RST,1) + max(T_INT,1) + max(T_SH,1) + 2^CW + NCH*CW + 1 cycles.
- Conversion lag: comp_i high at the edge where counter = c gives a captured value of c+2, provided c+2 ≤ 2^CW-1. If c+2 > 2^CW-1, the channel captures 2^CW-1.
- CONT cleared mid-frame: the current frame completes, then the FSM goes to IDLE.

## Test plan
- Reset, then read all registers: every register reads 0. All outputs are 0 and irq=0.
- NCH=4, CW=8, T_RST=3, T_INT=5, T_SH=2, START. Drive comp_i[k] high when counter = 0x20k+0x10.
  - Phase widths are 3/5/2/256 cycles.
  - RESULT0..3 = 0x12, 0x32, 0x52, 0x72.
  - Serial stream is 0x12,0x32,0x52,0x72, MSB first, over 32 clk_o cycles, with start_o on bit 0.
  - done_o pulses once and irq[0]=1. Writing STATUS clears irq[0].
- comp_i held low for a whole frame: every RESULT = 0xFF and data_o is all ones for 32 bits.
- T_RST=T_INT=T_SH=0: each phase lasts exactly 1 cycle. START written while BUSY is ignored: FRAMES increments by 1 only.
- CONT=1 for 3 frames, then clear CONT: FRAMES=3, the FSM goes back to IDLE, and there is no gap between frames (DONE→RST).
- ABORT mid-CONV: the next cycle is IDLE with all outputs 0 and RESULT unchanged. wb_rst_i mid-SHIFT: data_o, clk_o and all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/rlbp_seq_if.sv
// Wishbone slave bundle between the Caravel wrapper and the readout sequencer.
interface rlbp_seq_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
        output wbs_dat_o, wbs_ack_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
        input  wbs_dat_o, wbs_ack_o
    );
endinterface

// File: rtl/rlbp_seq.sv
// MixPix readout sequencer: timed pixel phases, shared single-slope conversion of NCH channels, serial result shift-out.
// Wishbone ack one cycle after request, never stalls; frame = RST+INT+SAMP+2^CW+NCH*CW+1 cycles.
module rlbp_seq #(
    parameter int NCH = 4,
    parameter int CW  = 8
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    rlbp_seq_if.slave      wb,
    input  logic [NCH-1:0] comp_i,
    output logic           rst_o,
    output logic           Sh_rst,
    output logic           Sw1,
    output logic           Sh,
    output logic           Sw2,
    output logic           Sh_cmp,
    output logic           counter_rst,
    output logic           data_o,
    output logic           clk_o,
    output logic           start_o,
    output logic           done_o,
    output logic [2:0]     irq
);
    localparam int SHN = NCH * CW;

    typedef enum logic [2:0] {S_IDLE, S_RST, S_INT, S_SAMP, S_CONV, S_SHIFT, S_DONE} state_t;

    state_t         r_state, w_next;
    logic [7:0]     r_tmr;
    logic [CW-1:0]  r_cnt;
    logic [NCH-1:0] r_s1, r_s2, r_got;
    logic [CW-1:0]  r_cap [NCH];
    logic [CW-1:0]  r_res [NCH];
    logic [SHN-1:0] r_sh;
    logic           r_start, r_abort, r_cont, r_done, r_ack;
    logic [23:0]    r_timing;
    logic [7:0]     r_frames;
    logic [31:0]    r_dat;

    logic           w_req, w_wr, w_busy, w_tmr_end, w_to_shift;
    logic [3:0]     w_widx;
    logic [7:0]     w_len_raw, w_len;
    logic [CW-1:0]  w_final [NCH];
    logic [31:0]    w_rd;
    logic           w_unused;

    assign w_req    = wb.wbs_cyc_i & wb.wbs_stb_i & ~r_ack;
    assign w_wr     = w_req & wb.wbs_we_i;
    assign w_widx   = wb.wbs_adr_i[5:2];
    assign w_busy   = (r_state != S_IDLE);
    assign w_unused = ^{wb.wbs_sel_i, wb.wbs_adr_i[31:6], wb.wbs_adr_i[1:0], wb.wbs_dat_i[31:24]};

    always_comb begin
        case (r_state)
            S_RST:   w_len_raw = r_timing[7:0];
            S_INT:   w_len_raw = r_timing[15:8];
            S_SAMP:  w_len_raw = r_timing[23:16];
            default: w_len_raw = 8'd1;
        endcase
        w_len = (w_len_raw == 8'd0) ? 8'd1 : w_len_raw;
    end
    assign w_tmr_end = (r_tmr == w_len - 8'd1);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (r_start)   w_next = S_RST;
            S_RST:   if (w_tmr_end) w_next = S_INT;
            S_INT:   if (w_tmr_end) w_next = S_SAMP;
            S_SAMP:  if (w_tmr_end) w_next = S_CONV;
            S_CONV:  if (&r_cnt)    w_next = S_SHIFT;
            S_SHIFT: if (r_tmr == 8'(SHN - 1)) w_next = S_DONE;
            S_DONE:  w_next = r_cont ? S_RST : S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (r_abort) w_next = S_IDLE;
    end

    always_comb begin
        {rst_o, Sh_rst, Sw1, Sh, Sw2, Sh_cmp, counter_rst} = '0;
        data_o  = 1'b0;
        clk_o   = 1'b0;
        start_o = 1'b0;
        done_o  = 1'b0;
        case (r_state)
            S_RST:   {rst_o, Sh_rst, counter_rst} = 3'b111;
            S_INT:   {Sw1, counter_rst} = 2'b11;
            S_SAMP:  {Sh, counter_rst} = 2'b11;
            S_CONV:  {Sw2, Sh_cmp} = 2'b11;
            S_SHIFT: begin
                clk_o   = 1'b1;
                data_o  = r_sh[SHN-1];
                start_o = (r_tmr == 8'd0);
            end
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end
    assign irq = {2'b00, r_done};

    // A channel that never fired during CONV reports full scale.
    always_comb begin
        for (int k = 0; k < NCH; k++) w_final[k] = r_got[k] ? r_cap[k] : '1;
    end
    assign w_to_shift = (r_state == S_CONV) && (w_next == S_SHIFT);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_tmr <= '0;
            r_cnt <= '0;
            r_s1  <= '0;
            r_s2  <= '0;
            r_got <= '0;
            r_sh  <= '0;
            for (int k = 0; k < NCH; k++) begin
                r_cap[k] <= '0;
                r_res[k] <= '0;
            end
        end else begin
            r_tmr <= (w_next != r_state) ? 8'd0 : r_tmr + 8'd1;
            r_cnt <= (r_state == S_CONV && w_next == S_CONV) ? r_cnt + CW'(1) : '0;
            r_s1  <= comp_i;
            r_s2  <= r_s1;
            for (int k = 0; k < NCH; k++) begin
                if (r_state != S_CONV) begin
                    r_got[k] <= 1'b0;
                end else if (r_s2[k] && !r_got[k]) begin
                    r_got[k] <= 1'b1;
                    r_cap[k] <= r_cnt;
                end
            end
            if (w_to_shift) begin
                for (int k = 0; k < NCH; k++) begin
                    r_res[k]                   <= w_final[k];
                    r_sh[(NCH-1-k)*CW +: CW]   <= w_final[k];
                end
            end else if (r_state == S_SHIFT) begin
                r_sh <= {r_sh[SHN-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        w_rd = '0;
        case (w_widx)
            4'd0: w_rd = {30'd0, r_cont, 1'b0};
            4'd1: w_rd = {8'd0, r_timing};
            4'd2: w_rd = {16'd0, r_frames, 6'd0, r_done, w_busy};
            default: begin
                for (int k = 0; k < NCH; k++)
                    if (w_widx == 4'(8 + k)) w_rd = 32'(r_res[k]);
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_start  <= 1'b0;
            r_abort  <= 1'b0;
            r_cont   <= 1'b0;
            r_timing <= '0;
            r_done   <= 1'b0;
            r_frames <= '0;
        end else begin
            r_ack   <= w_req;
            r_start <= 1'b0;
            r_abort <= 1'b0;
            if (w_wr && w_widx == 4'd0) begin
                r_start <= wb.wbs_dat_i[0];
                r_cont  <= wb.wbs_dat_i[1];
                r_abort <= wb.wbs_dat_i[2];
            end
            if (w_wr && w_widx == 4'd1) r_timing <= wb.wbs_dat_i[23:0];
            if (w_req && !wb.wbs_we_i)  r_dat <= w_rd;
            if (w_wr && w_widx == 4'd2) r_done <= 1'b0;
            // End-of-frame set takes priority over a coincident STATUS clear.
            if (r_state == S_DONE && !r_abort) begin
                r_done   <= 1'b1;
                r_frames <= r_frames + 8'd1;
            end
        end
    end

    assign wb.wbs_ack_o = r_ack;
    assign wb.wbs_dat_o = r_dat;
endmodule
